price_calc_seq: RTL and testbench



---
 rtl/scale_pkg.sv | 20 ++
 rtl/div_by_const_seq.sv | 55 +++++
 rtl/price_calc_seq.sv | 125 ++++++++++++
 tb/tb_price_calc_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared definitions for the scale datapath: FSM states, unit constants and
// the width of the cents result derived from the raw product width.
package scale_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TARE,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam int unsigned GRAMS_PER_KG = 1000;
  localparam int unsigned ROUND_ADD    = 500;

  function automatic int unsigned quot_width(input int unsigned prod_w);
    return prod_w - 9;
  endfunction

endpackage

// File: rtl/div_by_const_seq.sv
// Restoring divider by a constant, one quotient bit per cycle, MSB first.
// Loads on start; done is high during the last iteration, with quotient valid then.
module div_by_const_seq #(
  parameter int unsigned DW      = 25,
  parameter int unsigned DIVISOR = 1000,
  parameter int unsigned QW      = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int unsigned RW = $clog2(DIVISOR) + 1;
  localparam int unsigned CW = $clog2(DW);

  logic [DW-1:0] q;
  logic [RW-2:0] rem;
  logic [CW-1:0] cnt;
  logic [RW-1:0] shifted;
  logic          ge;

  always_comb begin
    shifted = {rem, q[DW-1]};
    ge      = (shifted >= RW'(DIVISOR));
  end

  // Quotient is taken from the bit being resolved this cycle, so the owner
  // can capture it on the same edge that finishes the division.
  assign done     = busy && (cnt == CW'(DW - 1));
  assign quotient = {q[QW-2:0], ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      rem  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      q    <= dividend;
      rem  <= '0;
    end else if (busy) begin
      q   <= {q[DW-2:0], ge};
      rem <= ge ? (RW-1)'(shifted - RW'(DIVISOR)) : shifted[RW-2:0];
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/price_calc_seq.sv
// Sequential price calculator: (gross - tare) x cents/kg, then / 1000 to cents.
// Define PRICE_ROUND_EN to round half-up instead of truncating.
module price_calc_seq
  import scale_pkg::*;
#(
  parameter  int unsigned W_WIDTH = 12,
  parameter  int unsigned P_WIDTH = 12,
  localparam int unsigned PROD_W  = W_WIDTH + P_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [W_WIDTH-1:0]            weightInGrams,
  input  logic [W_WIDTH-1:0]            tareInGrams,
  input  logic [P_WIDTH-1:0]            centimos,
  output logic                          busy,
  output logic                          done,
  output logic                          underTare,
  output logic [PROD_W-1:0]             precotara,
  output logic [quot_width(PROD_W)-1:0] precof
);

  localparam int unsigned QW = quot_width(PROD_W);
  localparam int unsigned DW = PROD_W + 1;
  localparam int unsigned CW = $clog2(W_WIDTH + 1);

  state_t              state, state_nxt;
  logic [W_WIDTH-1:0]  gross, tare, net;
  logic [PROD_W-1:0]   mcand, acc, acc_next;
  logic [CW-1:0]       cnt;
  logic                mul_last;
  logic                div_start, div_busy, div_done;
  logic [DW-1:0]       dividend;
  logic [QW-1:0]       div_quot;

  assign acc_next  = acc + (net[0] ? mcand : '0);
  assign mul_last  = (cnt == CW'(W_WIDTH - 1));
  // Divider is loaded on the final multiply edge from the product being
  // completed, so DIV spends exactly DW cycles iterating.
  assign div_start = (state == MUL) && mul_last;

`ifdef PRICE_ROUND_EN
  assign dividend = {1'b0, acc_next} + DW'(ROUND_ADD);
`else
  assign dividend = {1'b0, acc_next};
`endif

  div_by_const_seq #(
    .DW      (DW),
    .DIVISOR (GRAMS_PER_KG),
    .QW      (QW)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = TARE;
      TARE:    state_nxt = MUL;
      MUL:     if (mul_last) state_nxt = DIV;
      DIV:     if (div_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gross     <= '0;
      tare      <= '0;
      net       <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      underTare <= 1'b0;
      precotara <= '0;
      precof    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          gross <= weightInGrams;
          tare  <= tareInGrams;
          mcand <= PROD_W'(centimos);
          acc   <= '0;
        end
        TARE: begin
          cnt <= '0;
          if (tare > gross) begin
            net       <= '0;
            underTare <= 1'b1;
          end else begin
            net       <= gross - tare;
            underTare <= 1'b0;
          end
        end
        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          net   <= net >> 1;
          cnt   <= cnt + 1'b1;
        end
        DIV: if (div_done) begin
          precotara <= acc;
          precof    <= div_quot;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_price_calc_seq.sv
// Directed bench for price_calc_seq: latency, results, underTare, start
// filtering, output hold and mid-operation reset.
module tb_price_calc_seq;

  localparam int unsigned W_WIDTH = 12;
  localparam int unsigned P_WIDTH = 12;
  localparam int unsigned PROD_W  = 24;
  localparam int unsigned QW      = 15;
  localparam int unsigned LAT     = 39;

  logic               clk = 1'b0;
  logic               reset, start;
  logic [W_WIDTH-1:0] weightInGrams, tareInGrams;
  logic [P_WIDTH-1:0] centimos;
  logic               busy, done, underTare;
  logic [PROD_W-1:0]  precotara;
  logic [QW-1:0]      precof;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [PROD_W-1:0] last_prod  = '0;
  logic [QW-1:0]     last_price = '0;

  price_calc_seq #(.W_WIDTH(W_WIDTH), .P_WIDTH(P_WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .weightInGrams (weightInGrams),
    .tareInGrams   (tareInGrams),
    .centimos      (centimos),
    .busy          (busy),
    .done          (done),
    .underTare     (underTare),
    .precotara     (precotara),
    .precof        (precof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction. inject_at > 0 pulses start with other operands
  // on that cycle of the run, which must be ignored.
  task automatic run(input string tag, input logic [11:0] w, input logic [11:0] t,
                     input logic [11:0] p, input logic [23:0] eprod,
                     input logic [14:0] eprice, input logic eut, input int inject_at);
    int n;
    bit seen;
    @(negedge clk);
    weightInGrams = w;
    tareInGrams   = t;
    centimos      = p;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    weightInGrams = 12'hFFF;
    tareInGrams   = 12'h5A5;
    centimos      = 12'hFFF;
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == inject_at);
      if (n == inject_at) begin
        weightInGrams = 12'd4095;
        tareInGrams   = 12'd0;
        centimos      = 12'd4095;
      end
      if (n == 1) check({tag, " busy_after_accept"}, busy, 1);
      if (n == 2) check({tag, " hold_prev_prod"}, precotara, last_prod);
      if (done) seen = 1;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " busy_at_done"}, busy, 1);
    check({tag, " precotara"}, precotara, eprod);
    check({tag, " precof"}, precof, eprice);
    check({tag, " underTare"}, underTare, eut);
    last_prod  = eprod;
    last_price = eprice;
    // start during the DONE cycle must not launch a new run
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, " done_pulse_width"}, done, 0);
    check({tag, " idle_after_done"}, busy, 0);
    check({tag, " hold_precof"}, precof, eprice);
  endtask

  initial begin
    bit dn;
    reset         = 1'b1;
    start         = 1'b0;
    weightInGrams = '0;
    tareInGrams   = '0;
    centimos      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset underTare", underTare, 0);
    check("reset precotara", precotara, 0);
    check("reset precof", precof, 0);

    run("basic", 12'd1500, 12'd0, 12'd470, 24'd705000, 15'd705, 1'b0, 0);
    run("tare", 12'd1500, 12'd200, 12'd470, 24'd611000, 15'd611, 1'b0, 0);
    run("undertare", 12'd100, 12'd300, 12'd470, 24'd0, 15'd0, 1'b1, 0);
    run("equal_tare", 12'd500, 12'd500, 12'd100, 24'd0, 15'd0, 1'b0, 0);
`ifdef PRICE_ROUND_EN
    run("round", 12'd1500, 12'd0, 12'd1, 24'd1500, 15'd2, 1'b0, 0);
`else
    run("round", 12'd1500, 12'd0, 12'd1, 24'd1500, 15'd1, 1'b0, 0);
`endif
    run("max", 12'd4095, 12'd0, 12'd4095, 24'd16769025, 15'd16769, 1'b0, 0);
    run("zero_weight", 12'd0, 12'd0, 12'd470, 24'd0, 15'd0, 1'b0, 0);
    run("zero_price", 12'd1000, 12'd0, 12'd0, 24'd0, 15'd0, 1'b0, 0);
    run("start_busy", 12'd1300, 12'd0, 12'd470, 24'd611000, 15'd611, 1'b0, 5);

    // hold across idle cycles
    repeat (5) @(negedge clk);
    check("idle hold precotara", precotara, 24'd611000);
    check("idle hold precof", precof, 15'd611);

    // reset ten cycles into a run
    @(negedge clk);
    weightInGrams = 12'd4095;
    tareInGrams   = 12'd0;
    centimos      = 12'd4095;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 0);
    check("midreset precotara", precotara, 0);
    check("midreset precof", precof, 0);
    check("midreset underTare", underTare, 0);
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dn = 1;
    end
    check("midreset no_done", dn, 0);
    last_prod  = '0;
    last_price = '0;
    run("after_reset", 12'd1500, 12'd200, 12'd470, 24'd611000, 15'd611, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
